// File: rtl/connect4_uart_pkg.sv
// connect4_uart_pkg: shared constants and types for the UART command decoder.
package connect4_uart_pkg;

    localparam logic [7:0] SOF_BYTE   = 8'hA5;
    localparam logic [7:0] BYTE_LEFT  = 8'h01;
    localparam logic [7:0] BYTE_RIGHT = 8'h02;
    localparam logic [7:0] BYTE_DROP  = 8'h03;
    localparam logic [7:0] BYTE_RESET = 8'h04;

    typedef enum logic [1:0] {CMD_LEFT, CMD_RIGHT, CMD_DROP, CMD_RESET} cmd_t;

    typedef enum logic [1:0] {ST_IDLE, ST_GOT_SOF, ST_GOT_CMD} state_t;

    function automatic logic is_known(input logic [7:0] b);
        return b inside {BYTE_LEFT, BYTE_RIGHT, BYTE_DROP, BYTE_RESET};
    endfunction

    // Command bytes 01..04 map onto enum values 0..3.
    function automatic cmd_t to_cmd(input logic [7:0] b);
        return cmd_t'(2'(b - 8'd1));
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: small synchronous FIFO of decoded commands; pushes while full are ignored.
module cmd_fifo
    import connect4_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic push,
    input  logic pop,
    input  cmd_t din,
    output cmd_t dout,
    output logic empty,
    output logic full
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem_q [DEPTH];
    cmd_t          mem_d [DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic          push_ok, pop_ok;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_q[AW-1:0]] = din;
        wr_d = wr_q + (AW+1)'(push_ok);
        rd_d = rd_q + (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= CMD_LEFT;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: parses A5/CMD/~CMD frames from the UART and replays them
// as spaced one-cycle button pulses for the connect-4 game FSM.
module uart_cmd_decoder
    import connect4_uart_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       move_left,
    output logic       move_right,
    output logic       move_made,
    output logic       reset_req,
    output logic [7:0] last_cmd,
    output logic       frame_err,
    output logic [7:0] err_count
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [3:0]    pulse_q, pulse_d;
    logic [7:0]    last_cmd_q, last_cmd_d;
    logic          err_q, err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          push, pop, timeout, empty, full;
    cmd_t          fifo_dout;

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rstn (rstn),
        .push (push),
        .pop  (pop),
        .din  (to_cmd(cmd_q)),
        .dout (fifo_dout),
        .empty(empty),
        .full (full)
    );

    // A byte arriving in the timeout cycle suppresses the timeout.
    assign timeout = (state_q != ST_IDLE) && !rx_valid && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign pop     = !empty && (gap_q == '0);

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        last_cmd_d = last_cmd_q;
        push       = 1'b0;
        err_d      = 1'b0;
        to_cnt_d   = (rx_valid || state_q == ST_IDLE || timeout) ? '0 : to_cnt_q + TW'(1);
        if (rx_valid) begin
            case (state_q)
                ST_IDLE:    state_d = (rx_data == SOF_BYTE) ? ST_GOT_SOF : ST_IDLE;
                ST_GOT_SOF: begin
                    cmd_d   = rx_data;
                    state_d = ST_GOT_CMD;
                end
                ST_GOT_CMD: begin
                    state_d = ST_IDLE;
                    if (rx_data == ~cmd_q && is_known(cmd_q)) begin
                        push       = 1'b1;
                        last_cmd_d = cmd_q;
                        err_d      = full;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default:    state_d = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
        gap_d     = pop ? GW'(GAP_CYCLES) : (gap_q != '0 ? gap_q - GW'(1) : gap_q);
        pulse_d   = pop ? 4'b0001 << fifo_dout : 4'b0000;
        err_cnt_d = (err_q && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            to_cnt_q   <= '0;
            gap_q      <= '0;
            pulse_q    <= '0;
            last_cmd_q <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            to_cnt_q   <= to_cnt_d;
            gap_q      <= gap_d;
            pulse_q    <= pulse_d;
            last_cmd_q <= last_cmd_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign move_left  = pulse_q[CMD_LEFT];
    assign move_right = pulse_q[CMD_RIGHT];
    assign move_made  = pulse_q[CMD_DROP];
    assign reset_req  = pulse_q[CMD_RESET];
    assign last_cmd   = last_cmd_q;
    assign frame_err  = err_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed frames against hand-computed pulse counts and timing.
module tb_uart_cmd_decoder;

    localparam int GAP = 20;
    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       move_left, move_right, move_made, reset_req, frame_err;
    logic [7:0] last_cmd, err_count;

    uart_cmd_decoder #(
        .FIFO_DEPTH    (4),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .move_left (move_left),
        .move_right(move_right),
        .move_made (move_made),
        .reset_req (reset_req),
        .last_cmd  (last_cmd),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int n_left, n_right, n_made, n_reset, n_err;
    int t_left, t_right, t_made, t_reset, t_err;
    int bad = 0;
    logic [4:0] p, prev = '0;

    // Counters restart on every reset; shape violations are never forgotten.
    always @(posedge clk) begin
        #1;
        p = {frame_err, reset_req, move_made, move_right, move_left};
        if (!$onehot0(p[3:0]) || (p & prev) != '0) bad++;
        prev = p;
        if (!rstn) begin
            n_left = 0; n_right = 0; n_made = 0; n_reset = 0; n_err = 0;
            t_left = 0; t_right = 0; t_made = 0; t_reset = 0; t_err = 0;
        end else begin
            if (move_left)  begin n_left++;  t_left  = cyc; end
            if (move_right) begin n_right++; t_right = cyc; end
            if (move_made)  begin n_made++;  t_made  = cyc; end
            if (reset_req)  begin n_reset++; t_reset = cyc; end
            if (frame_err)  begin n_err++;   t_err   = cyc; end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] k);
        send(8'hA5);
        send(c);
        send(k);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    int t_n;

    initial begin
        @(negedge clk);
        idle(2);
        chk("rst_pulses", 32'({move_left, move_right, move_made, reset_req, frame_err}), 0);
        chk("rst_last_cmd", 32'(last_cmd), 0);
        chk("rst_err_count", 32'(err_count), 0);
        rstn = 1'b1;
        idle(1);

        send(8'hA5); send(8'h03); t_n = cyc; send(8'hFC);
        idle(30);
        chk("t1_made_n", n_made, 1);
        chk("t1_made_t", t_made, t_n + 2);
        chk("t1_last_cmd", 32'(last_cmd), 32'h03);
        chk("t1_err_count", 32'(err_count), 0);
        chk("t1_other", n_left + n_right + n_reset + n_err, 0);

        do_reset;
        send(8'hA5); send(8'h01); t_n = cyc; send(8'hFE);
        frame(8'h02, 8'hFD);
        idle(50);
        chk("t2_left_n", n_left, 1);
        chk("t2_left_t", t_left, t_n + 2);
        chk("t2_right_n", n_right, 1);
        chk("t2_right_t", t_right, t_left + GAP + 1);
        chk("t2_other", n_made + n_reset + n_err, 0);
        chk("t2_last_cmd", 32'(last_cmd), 32'h02);

        do_reset;
        frame(8'h03, 8'hFC);
        idle(30);
        frame(8'h02, 8'h00);
        frame(8'h07, 8'hF8);
        idle(30);
        chk("t3_err_n", n_err, 2);
        chk("t3_err_count", 32'(err_count), 2);
        chk("t3_last_cmd", 32'(last_cmd), 32'h03);
        chk("t3_moves", n_left + n_right + n_reset, 0);
        chk("t3_made_n", n_made, 1);

        do_reset;
        t_n = cyc; send(8'hA5);
        idle(TMO);
        send(8'h01); send(8'hFE);
        idle(30);
        chk("t4_err_n", n_err, 1);
        chk("t4_err_t", t_err, t_n + TMO + 1);
        chk("t4_err_count", 32'(err_count), 1);
        chk("t4_left_n", n_left, 0);

        do_reset;
        send(8'hA5);
        idle(TMO - 1);
        send(8'h01); send(8'hFE);
        idle(30);
        chk("t4b_err_n", n_err, 0);
        chk("t4b_left_n", n_left, 1);
        chk("t4b_last_cmd", 32'(last_cmd), 32'h01);

        do_reset;
        repeat (6) frame(8'h03, 8'hFC);
        idle(6 * GAP + 30);
        chk("t5_made_n", n_made, 5);
        chk("t5_err_n", n_err, 1);
        chk("t5_err_count", 32'(err_count), 1);
        chk("t5_last_cmd", 32'(last_cmd), 32'h03);

        do_reset;
        frame(8'h04, 8'hFB);
        frame(8'h04, 8'hFB);
        idle(5);
        chk("t6_reset_n", n_reset, 1);
        rstn = 1'b0;
        #1;
        chk("t6_async_outs", 32'({move_left, move_right, move_made, reset_req, frame_err}), 0);
        chk("t6_async_last_cmd", 32'(last_cmd), 0);
        @(negedge clk);
        rstn = 1'b1;
        idle(GAP + 20);
        chk("t6_queue_lost", n_reset, 0);
        send(8'h11); send(8'h22);
        frame(8'h01, 8'hFE);
        idle(10);
        chk("t6_stray_err", n_err, 0);
        chk("t6_left_n", n_left, 1);
        chk("t6_err_count", 32'(err_count), 0);

        do_reset;
        repeat (260) frame(8'h00, 8'h00);
        idle(5);
        chk("t7_err_n", n_err, 260);
        chk("t7_err_sat", 32'(err_count), 32'hFF);

        chk("pulse_shape", bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
